accel_spi_reader: RTL and testbench

- SPI master that configures an ADXL345-class 3-axis accelerometer, then polls its X and Y axes periodically.
- Presents 8-bit signed X/Y samples as accel_data_x / accel_data_y to the game logic stage, which samples them at end of frame.
- Sits between the board-level SPI pins and the game logic. Runs entirely in the pixel_clk domain.

---
 rtl/accel_spi_reader.sv | 181 ++++++++++++++++++
 tb/tb_accel_spi_reader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/accel_spi_reader.sv
// rtl/accel_spi_reader.sv - SPI mode-3 master that configures an ADXL345-class accelerometer and polls X/Y
// Optional ACCEL_AVG_EN: outputs become the 4-sample running average of each axis.
module accel_spi_reader #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 36000,
    parameter int PWRUP_CYCLES  = 72000
) (
    input  logic       pixel_clk,
    input  logic       rst,
    output logic       spi_sclk,
    output logic       spi_cs_n,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic [7:0] accel_data_x,
    output logic [7:0] accel_data_y,
    output logic       data_valid,
    output logic       init_done
);
    localparam logic [2:0] S_PWRUP  = 3'd0;
    localparam logic [2:0] S_WR_FMT = 3'd1;
    localparam logic [2:0] S_WR_PWR = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_READ   = 3'd4;
    localparam logic [2:0] S_UPDATE = 3'd5;

    localparam logic [1:0] PH_SETUP = 2'd0;
    localparam logic [1:0] PH_BIT   = 2'd1;
    localparam logic [1:0] PH_HOLD  = 2'd2;
    localparam logic [1:0] PH_GAP   = 2'd3;

    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int PW_W  = $clog2(PWRUP_CYCLES);
    localparam int SP_W  = $clog2(SAMPLE_PERIOD);
    localparam logic [DIV_W-1:0] HALF      = DIV_W'(CLK_DIV);
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] FULL_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [PW_W-1:0]  PW_LAST   = PW_W'(PWRUP_CYCLES - 1);
    localparam logic [SP_W-1:0]  SP_LAST   = SP_W'(SAMPLE_PERIOD - 1);
`ifdef ACCEL_AVG_EN
    localparam int RAW_LSB = 0;
`else
    localparam int RAW_LSB = 2;
`endif

    logic [2:0]       state;
    logic [1:0]       phase;
    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       bit_cnt;
    logic [5:0]       cap_cnt;
    logic [PW_W-1:0]  pwr_cnt;
    logic [SP_W-1:0]  timer;
    logic             timer_run;
    logic             pending;
    logic [39:0]      tx_sr;
    logic [6:0]       rx_byte;
    logic             miso_meta, miso_s;
    logic             rise_d1, rise_d2;
    logic [9:RAW_LSB] raw_x, raw_y;
`ifdef ACCEL_AVG_EN
    logic [9:0]       hist_x0, hist_x1, hist_x2;
    logic [9:0]       hist_y0, hist_y1, hist_y2;

    function automatic logic [7:0] avg4(input logic [9:0] a, input logic [9:0] b,
                                        input logic [9:0] c, input logic [9:0] d);
        logic signed [11:0] s;
        s = {{2{a[9]}}, a} + {{2{b[9]}}, b} + {{2{c[9]}}, c} + {{2{d[9]}}, d};
        return 8'(s >>> 4);
    endfunction
`endif

    logic       txn, rise, txn_done, timer_hit, read_go;
    logic [5:0] last_bit;
    logic [7:0] cap_byte;

    assign txn       = (state == S_WR_FMT) || (state == S_WR_PWR) || (state == S_READ);
    assign rise      = txn && (phase == PH_BIT) && (div_cnt == HALF);
    assign txn_done  = txn && (phase == PH_GAP) && (div_cnt == FULL_LAST);
    assign timer_hit = timer_run && (timer == SP_LAST);
    assign read_go   = ((state == S_WAIT) || (state == S_UPDATE)) && (timer_hit || pending);
    assign last_bit  = (state == S_READ) ? 6'd39 : 6'd15;
    assign cap_byte  = {rx_byte, miso_s};

    assign spi_cs_n = !(txn && (phase != PH_GAP));
    assign spi_sclk = !(txn && (phase == PH_BIT) && (div_cnt < HALF));
    assign spi_mosi = txn && (phase == PH_BIT) && tx_sr[39];

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state <= S_PWRUP;  phase <= PH_SETUP;  div_cnt <= '0;  bit_cnt <= '0;
            cap_cnt <= '0;  pwr_cnt <= '0;  timer <= '0;  timer_run <= 1'b0;
            pending <= 1'b0;  tx_sr <= '0;  rx_byte <= '0;
            miso_meta <= 1'b0;  miso_s <= 1'b0;  rise_d1 <= 1'b0;  rise_d2 <= 1'b0;
            raw_x <= '0;  raw_y <= '0;
            accel_data_x <= '0;  accel_data_y <= '0;  data_valid <= 1'b0;  init_done <= 1'b0;
`ifdef ACCEL_AVG_EN
            hist_x0 <= '0;  hist_x1 <= '0;  hist_x2 <= '0;
            hist_y0 <= '0;  hist_y1 <= '0;  hist_y2 <= '0;
`endif
        end else begin
            data_valid <= 1'b0;
            miso_meta  <= spi_miso;
            miso_s     <= miso_meta;
            rise_d1    <= rise;
            rise_d2    <= rise_d1;
            if (timer_run)
                timer <= timer_hit ? '0 : timer + 1'b1;
            if (read_go)
                pending <= 1'b0;
            else if (timer_hit)
                pending <= 1'b1;

            // MISO is taken two cycles after SCLK rises to cover the synchroniser delay
            if (rise_d2 && state == S_READ) begin
                rx_byte <= cap_byte[6:0];
                cap_cnt <= cap_cnt + 1'b1;
                if (cap_cnt[2:0] == 3'd7) begin
                    case (cap_cnt[5:3])
                        3'd1: raw_x[7:RAW_LSB] <= cap_byte[7:RAW_LSB];
                        3'd2: raw_x[9:8]       <= cap_byte[1:0];
                        3'd3: raw_y[7:RAW_LSB] <= cap_byte[7:RAW_LSB];
                        3'd4: raw_y[9:8]       <= cap_byte[1:0];
                        default: ;
                    endcase
                end
            end

            if (txn) begin
                case (phase)
                    PH_SETUP: if (div_cnt == HALF_LAST) begin
                        phase <= PH_BIT;  div_cnt <= '0;
                    end else div_cnt <= div_cnt + 1'b1;
                    PH_BIT: if (div_cnt == FULL_LAST) begin
                        div_cnt <= '0;
                        tx_sr   <= {tx_sr[38:0], 1'b0};
                        if (bit_cnt == last_bit) phase <= PH_HOLD;
                        else bit_cnt <= bit_cnt + 1'b1;
                    end else div_cnt <= div_cnt + 1'b1;
                    PH_HOLD: if (div_cnt == HALF_LAST) begin
                        phase <= PH_GAP;  div_cnt <= '0;
                    end else div_cnt <= div_cnt + 1'b1;
                    PH_GAP: div_cnt <= (div_cnt == FULL_LAST) ? '0 : div_cnt + 1'b1;
                endcase
            end

            // Entering a transaction below overrides the phase bookkeeping above
            case (state)
                S_PWRUP: if (pwr_cnt == PW_LAST) begin
                    state <= S_WR_FMT;  phase <= PH_SETUP;  div_cnt <= '0;  bit_cnt <= '0;
                    tx_sr <= {16'h3100, 24'h0};
                end else pwr_cnt <= pwr_cnt + 1'b1;
                S_WR_FMT: if (txn_done) begin
                    state <= S_WR_PWR;  phase <= PH_SETUP;  div_cnt <= '0;  bit_cnt <= '0;
                    tx_sr <= {16'h2D08, 24'h0};
                end
                S_WR_PWR: if (txn_done) begin
                    state <= S_WAIT;  init_done <= 1'b1;  timer <= '0;  timer_run <= 1'b1;
                end
                S_READ: if (txn_done) state <= S_UPDATE;
                S_WAIT, S_UPDATE: begin
                    if (state == S_UPDATE) begin
                        data_valid <= 1'b1;
`ifdef ACCEL_AVG_EN
                        accel_data_x <= avg4(raw_x, hist_x0, hist_x1, hist_x2);
                        accel_data_y <= avg4(raw_y, hist_y0, hist_y1, hist_y2);
                        hist_x2 <= hist_x1;  hist_x1 <= hist_x0;  hist_x0 <= raw_x;
                        hist_y2 <= hist_y1;  hist_y1 <= hist_y0;  hist_y0 <= raw_y;
`else
                        accel_data_x <= raw_x[9:2];
                        accel_data_y <= raw_y[9:2];
`endif
                    end
                    if (read_go) begin
                        state <= S_READ;  phase <= PH_SETUP;  div_cnt <= '0;  bit_cnt <= '0;
                        cap_cnt <= '0;  tx_sr <= {8'hF2, 32'h0};
                    end else state <= S_WAIT;
                end
                default: state <= S_PWRUP;
            endcase
        end
    end
endmodule

// File: tb/tb_accel_spi_reader.sv
// tb/tb_accel_spi_reader.sv - directed vector bench for accel_spi_reader with an SPI slave model
module tb_accel_spi_reader;
    localparam int CLK_DIV = 4;
    localparam int SP      = 600;
    localparam int PW      = 200;

    logic       pixel_clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_sclk, spi_cs_n, spi_mosi;
    logic       spi_miso = 1'b0;
    logic [7:0] accel_data_x, accel_data_y;
    logic       data_valid, init_done;

    accel_spi_reader #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SP), .PWRUP_CYCLES(PW)) dut (
        .pixel_clk(pixel_clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .accel_data_x(accel_data_x),
        .accel_data_y(accel_data_y), .data_valid(data_valid), .init_done(init_done));

    always #5 pixel_clk = ~pixel_clk;

    int n_vec = 0, n_err = 0;
    int cyc = 0;
    always @(posedge pixel_clk) cyc++;

    // Slave model and bus monitor
    logic [7:0]  sb [4];
    int          frame_bits[$];
    logic [39:0] frame_data[$];
    int          fall_cyc[$];
    int          cur_bits = 0, slave_idx = 0, last_rise = 0;
    logic [39:0] cur_data = '0;
    logic        mosi_at_fall = 1'b0;
    int          period_bad = 0, mosi_bad = 0, hold_bad = 0;
    bit          hold_mon = 1'b0;
    logic [7:0]  last_x = '0, last_y = '0;

    always @(negedge spi_cs_n) begin
        cur_bits = 0;  cur_data = '0;  slave_idx = 0;
        fall_cyc.push_back(cyc);
    end
    always @(posedge spi_cs_n) begin
        frame_bits.push_back(cur_bits);
        frame_data.push_back(cur_data);
    end
    always @(posedge spi_sclk) if (spi_cs_n === 1'b0) begin
        if (cur_bits > 0 && cyc - last_rise != 2 * CLK_DIV) period_bad++;
        last_rise = cyc;
        if (spi_mosi !== mosi_at_fall) mosi_bad++;
        cur_bits++;
        cur_data = {cur_data[38:0], spi_mosi};
    end
    always @(negedge spi_sclk) if (spi_cs_n === 1'b0) begin
        logic [7:0] b;
        #1;
        mosi_at_fall = spi_mosi;
        if (slave_idx >= 8 && slave_idx < 40) begin
            b = sb[(slave_idx - 8) / 8];
            spi_miso = b[7 - ((slave_idx - 8) % 8)];
        end else spi_miso = 1'b0;
        slave_idx++;
    end
    always @(negedge pixel_clk) begin
        if (hold_mon && !data_valid && (accel_data_x !== last_x || accel_data_y !== last_y))
            hold_bad++;
        last_x = accel_data_x;
        last_y = accel_data_y;
    end

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_dv(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 4 * SP && !ok; i++) begin
            @(negedge pixel_clk);
            if (data_valid === 1'b1) ok = 1'b1;
        end
        if (!ok) check({name, "_dv_timeout"}, 40'd0, 40'd1);
    endtask

    task automatic set_bytes(input logic [7:0] x0, input logic [7:0] x1,
                             input logic [7:0] y0, input logic [7:0] y1);
        sb[0] = x0;  sb[1] = x1;  sb[2] = y0;  sb[3] = y1;
    endtask

    // Release reset and check the power-up wait plus both configuration frames
    task automatic run_init(input string tag);
        int rel;
        bit ok = 1'b0;
        rst = 1'b0;
        rel = cyc;
        frame_bits.delete();  frame_data.delete();  fall_cyc.delete();
        for (int i = 0; i < PW + 50 && fall_cyc.size() == 0; i++) @(negedge pixel_clk);
        if (fall_cyc.size() == 0) check({tag, "_cs_timeout"}, 40'd0, 40'd1);
        else check({tag, "_pwrup_len"}, 40'(fall_cyc[0] - rel), 40'(PW));
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge pixel_clk);
            if (init_done === 1'b1) ok = 1'b1;
        end
        check({tag, "_init_done"}, 40'(ok), 40'd1);
        check({tag, "_frames_at_init"}, 40'(frame_bits.size()), 40'd2);
        if (frame_bits.size() >= 2) begin
            check({tag, "_fmt_bits"}, 40'(frame_bits[0]), 40'd16);
            check({tag, "_fmt_data"}, frame_data[0], 40'h3100);
            check({tag, "_pwr_bits"}, 40'(frame_bits[1]), 40'd16);
            check({tag, "_pwr_data"}, frame_data[1], 40'h2D08);
        end
    endtask

    typedef struct {
        logic [7:0] x0, x1, y0, y1;
        logic [7:0] ex, ey;
    } vec_t;
    vec_t vecs[5];

    initial begin
        int base;
`ifdef ACCEL_AVG_EN
        logic [7:0] avg_exp [5];
        avg_exp[0] = 8'h19;  avg_exp[1] = 8'h32;  avg_exp[2] = 8'h4B;
        avg_exp[3] = 8'h64;  avg_exp[4] = 8'h64;
`endif
        vecs[0] = '{8'h80, 8'h00, 8'h00, 8'hFF, 8'h20, 8'hC0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 8'hFE, 8'h7F, 8'h80};
        vecs[2] = '{8'h03, 8'h00, 8'hFD, 8'hFF, 8'h00, 8'hFF};
        vecs[3] = '{8'h5A, 8'h02, 8'h44, 8'h01, 8'h96, 8'h51};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        repeat (3) @(negedge pixel_clk);
        check("rst_cs_n", 40'(spi_cs_n), 40'd1);
        check("rst_sclk", 40'(spi_sclk), 40'd1);
        check("rst_mosi", 40'(spi_mosi), 40'd0);
        check("rst_x", 40'(accel_data_x), 40'd0);
        check("rst_y", 40'(accel_data_y), 40'd0);
        check("rst_dv", 40'(data_valid), 40'd0);
        check("rst_init", 40'(init_done), 40'd0);

`ifdef ACCEL_AVG_EN
        set_bytes(8'h90, 8'h01, 8'h00, 8'h00);
`else
        set_bytes(vecs[0].x0, vecs[0].x1, vecs[0].y0, vecs[0].y1);
`endif
        run_init("init");
        hold_mon = 1'b1;

        for (int i = 0; i < 5; i++) begin
            wait_dv($sformatf("read%0d", i));
`ifdef ACCEL_AVG_EN
            check($sformatf("avg%0d_x", i), 40'(accel_data_x), 40'(avg_exp[i]));
            check($sformatf("avg%0d_y", i), 40'(accel_data_y), 40'd0);
`else
            check($sformatf("vec%0d_x", i), 40'(accel_data_x), 40'(vecs[i].ex));
            check($sformatf("vec%0d_y", i), 40'(accel_data_y), 40'(vecs[i].ey));
`endif
            @(negedge pixel_clk);
            check($sformatf("read%0d_dv_width", i), 40'(data_valid), 40'd0);
`ifndef ACCEL_AVG_EN
            if (i < 4) set_bytes(vecs[i+1].x0, vecs[i+1].x1, vecs[i+1].y0, vecs[i+1].y1);
`endif
        end

        check("read_frame_count", 40'(frame_bits.size()), 40'd7);
        for (int k = 2; k < 7 && k < frame_bits.size(); k++) begin
            check($sformatf("read%0d_bits", k - 2), 40'(frame_bits[k]), 40'd40);
            check($sformatf("read%0d_cmd", k - 2), frame_data[k], 40'hF2_0000_0000);
            if (k < 6) check($sformatf("read%0d_spacing", k - 2),
                             40'(fall_cyc[k+1] - fall_cyc[k]), 40'(SP));
        end

        // Reset during the third byte of a read
        hold_mon = 1'b0;
        base = fall_cyc.size();
        for (int i = 0; i < 2 * SP && fall_cyc.size() == base; i++) @(negedge pixel_clk);
        check("midread_cs_seen", 40'(fall_cyc.size() > base), 40'd1);
        repeat (150) @(negedge pixel_clk);
        rst = 1'b1;
        @(negedge pixel_clk);
        check("midrst_cs_n", 40'(spi_cs_n), 40'd1);
        check("midrst_sclk", 40'(spi_sclk), 40'd1);
        check("midrst_mosi", 40'(spi_mosi), 40'd0);
        check("midrst_x", 40'(accel_data_x), 40'd0);
        check("midrst_y", 40'(accel_data_y), 40'd0);
        check("midrst_init", 40'(init_done), 40'd0);
        repeat (2) @(negedge pixel_clk);
        set_bytes(vecs[0].x0, vecs[0].x1, vecs[0].y0, vecs[0].y1);
        run_init("reinit");
        wait_dv("postrst");
`ifdef ACCEL_AVG_EN
        check("postrst_x", 40'(accel_data_x), 40'h08);
        check("postrst_y", 40'(accel_data_y), 40'hF0);
`else
        check("postrst_x", 40'(accel_data_x), 40'h20);
        check("postrst_y", 40'(accel_data_y), 40'hC0);
`endif

        check("sclk_period", 40'(period_bad), 40'd0);
        check("mosi_stable", 40'(mosi_bad), 40'd0);
        check("output_hold", 40'(hold_bad), 40'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
